// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation modes and FSM states.
package muldiv_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6
   } md_mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // True for the modes that occupy the unit for several cycles.
   function automatic logic md_is_long(input logic [3:0] m);
      return (m == MD_MULT) || (m == MD_MULTU) || (m == MD_DIV) || (m == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing {hi, lo}.
// Division works on magnitudes and re-applies signs afterwards, which makes the
// most-negative / -1 case fall out naturally as LO = most-negative, HI = 0.
module md_arith #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   input  logic             is_div,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);

   logic                 a_neg;
   logic                 b_neg;
   logic [2*WIDTH-1:0]   a_ext;
   logic [2*WIDTH-1:0]   b_ext;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH-1:0]     divisor;
   logic [WIDTH-1:0]     q_mag;
   logic [WIDTH-1:0]     r_mag;

   // Multiply via sign/zero extension; divide via magnitudes with sign fix-up.
   // NOTE: every output of a combinational block gets a value on every path (here
   // unconditionally up front) so that no latch is inferred.
   always_comb begin
      a_neg   = is_signed & a[WIDTH-1];
      b_neg   = is_signed & b[WIDTH-1];
      a_ext   = {{WIDTH{a_neg}}, a};
      b_ext   = {{WIDTH{b_neg}}, b};
      prod    = a_ext * b_ext;
      a_mag   = a_neg ? -a : a;
      b_mag   = b_neg ? -b : b;
      dz      = is_div && (b == '0);
      // Substitute a harmless divisor so a zero divide never produces X.
      divisor = dz ? WIDTH'(1) : b_mag;
      q_mag   = a_mag / divisor;
      r_mag   = a_mag % divisor;
      {hi, lo} = prod;
      if (is_div) begin
         lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
         hi = a_neg ? -r_mag : r_mag;
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// The result is computed at accept time, held in pend registers, and committed
// to HI/LO after MUL_LAT or DIV_LAT cycles unless flushed or reset.
module hilo_muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_sel,
   input  logic             flush,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             start,
   output logic             div_by_zero
);

   import muldiv_pkg::*;

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   md_state_t        state;
   md_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] pend_hi;
   logic [WIDTH-1:0] pend_lo;
   logic             pend_dz;
   logic [WIDTH-1:0] ar_hi;
   logic [WIDTH-1:0] ar_lo;
   logic             ar_dz;
   logic             accept;
   logic             is_div_op;
   logic             commit;

   assign accept    = (state == ST_IDLE) && !flush;
   assign is_div_op = (mode == MD_DIV) || (mode == MD_DIVU);
   assign start     = accept && md_is_long(mode);
   assign busy      = (state == ST_RUN);
   assign out       = hilo_sel ? hi : lo;

   md_arith #(.WIDTH(WIDTH)) u_arith (
      .a         (a),
      .b         (b),
      .is_signed ((mode == MD_MULT) || (mode == MD_DIV)),
      .is_div    (is_div_op),
      .hi        (ar_hi),
      .lo        (ar_lo),
      .dz        (ar_dz)
   );

   // State register.
   // NOTE: sequential blocks use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; flush outranks the commit on the final cycle.
   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            if (flush) begin
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_W'(1)) begin
               commit    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Latency counter: loaded on accept, counts down while running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= is_div_op ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (state == ST_RUN) begin
         cnt <= flush ? '0 : cnt - CNT_W'(1);
      end
   end

   // Capture the computed result at accept time.
   // NOTE: pend registers carry no reset; they are only consumed after a load,
   // so resetting them would add reset fan-out without changing behaviour.
   always_ff @(posedge clk) begin
      if (start) begin
         pend_hi <= ar_hi;
         pend_lo <= ar_lo;
         pend_dz <= ar_dz;
      end
   end

   // HI/LO update: commit of a finished op, or a direct move in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         if (!pend_dz) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else if (accept && (mode == MD_MTHI)) begin
         hi <= a;
      end else if (accept && (mode == MD_MTLO)) begin
         lo <= a;
      end
   end

   // One-cycle divide-by-zero pulse following the accepting cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) div_by_zero <= 1'b0;
      else        div_by_zero <= start && ar_dz;
   end

endmodule
